frame_read_ctrl: RTL and testbench
==================================

Name: frame_read_ctrl

Overview:
- Consumer end of the frame-buffer handoff. Detects the new-frame flag and latches the frame-buffer read index.
- Reads that frame from external memory as fixed-length bursts and streams the pixels to the display FIFO.
- Pulses frame_finish when the last word has arrived; frame_finish drives old_frame_finish of the frame-sign generator.
- Sits between the frame-sign generator, the memory read port and the output pixel FIFO.

Parameters:
- ADDR_W, 25, memory word-address width.
- DATA_W, 32, memory/pixel data width.
- BURST_LEN, 64, words per read burst (power of two, at least 2).
- FRAME_BURSTS, 12288, bursts per frame.
- FRAME_STRIDE, 786432, word distance between consecutive frame buffers (at least BURST_LEN*FRAME_BURSTS).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- new_frame, in, 1, level flag from the frame-sign generator; its rising edge starts a frame.
- read_index, in, 2, buffer index to read; valid from 2 cycles after the new_frame rising edge.
- rd_req, out, 1, burst request; held until rd_ack.
- rd_addr, out, ADDR_W, burst start word address.
- rd_len, out, 8, burst length; constant BURST_LEN-1.
- rd_ack, in, 1, request accepted in this cycle.
- rd_data_valid, in, 1, read data beat.
- rd_data, in, DATA_W, read data.
- pix_afull, in, 1, downstream FIFO almost full.
- pix_valid, out, 1, pixel write strobe.
- pix_data, out, DATA_W, pixel data.
- frame_finish, out, 1, one-cycle pulse when a frame completes.
- busy, out, 1, high from the start of ARM until DONE is left.
- overrun, out, 1, sticky error flag.

Behaviour:
- Reset (sync, rst=1):
  - Outputs: rd_req=0, rd_addr=0, pix_valid=0, pix_data=0, frame_finish=0, busy=0, overrun=0.
  - State: FSM=IDLE, counters=0, pending=0, new_frame_d=0.
  - A reset mid-frame abandons the frame without a frame_finish. Late data beats after reset are dropped.
- Edge detect: new_frame_d <= new_frame; start = new_frame & ~new_frame_d. Because new_frame_d resets to 0, a new_frame already high at reset release starts a frame.
- FSM states and transitions:
  - IDLE: on start or pending go to ARM and clear pending.
  - ARM: wait exactly 2 cycles, then latch read_index into idx_q and set burst_cnt=0. Go to REQ. The wait covers the generator's index update lag.
  - REQ: wait while pix_afull=1, with rd_req held low. Then assert rd_req with rd_addr = idx_q*FRAME_STRIDE + burst_cnt*BURST_LEN, computed mod 2^ADDR_W. rd_addr stays stable while rd_req=1. When rd_req & rd_ack, drop rd_req the next cycle and go to DATA.
  - DATA: each rd_data_valid gives pix_valid=1 and pix_data=rd_data, registered with 1-cycle latency, and increments beat_cnt. On the BURST_LEN-th beat, clear beat_cnt. If burst_cnt==FRAME_BURSTS-1 go to DONE; otherwise increment burst_cnt and go to REQ.
  - DONE: frame_finish=1 for exactly one cycle, then go to IDLE.
- At most one burst is outstanding. pix_afull is only sampled in REQ; an in-flight burst is always fully accepted.
- A start seen outside IDLE sets pending=1, so it is serviced immediately after DONE. Multiple starts while busy collapse into one pending.
- rd_data_valid outside DATA is dropped and sets overrun=1. overrun is sticky until rst.
- Counter widths: burst_cnt uses clog2(FRAME_BURSTS) bits, beat_cnt uses clog2(BURST_LEN) bits.
- Address multiply is on constants only, so a shift/add is acceptable.

Decomposition:
- Shared package frame_buf_pkg:
  - Constants BURST_LEN, FRAME_BURSTS, FRAME_STRIDE and NUM_BUFFERS=4.
  - FSM state typedef for IDLE, ARM, REQ, DATA, DONE.
  - Function base_addr(idx), shared with the write-side controller.
- Sub-module: edge_detect_rise (one flop plus AND), reused for new_frame.
- Everything else is flat.

Test Plan:
Test configuration: BURST_LEN=4, FRAME_BURSTS=3, FRAME_STRIDE=16, rd_ack returned 1 cycle after rd_req, 4 data beats returned 2 cycles after ack.
1. Release rst with new_frame=1, read_index=2.
   - Requests at rd_addr 32, 36, 40.
   - 12 pix_valid beats with data matching rd_data in order.
   - One frame_finish pulse, then busy=0.
2. Feed frame_finish back through the frame-sign generator model, which raises new_frame again with read_index=3.
   - Next addresses are 48, 52, 56.
3. Hold pix_afull=1 for 20 cycles before the 2nd request.
   - rd_req stays 0 throughout.
   - After release, the request is issued at address base+4 with no lost or duplicated beats.
4. Pulse new_frame low then high during burst 1.
   - The current frame completes normally.
   - The next frame's ARM starts the cycle after frame_finish; overrun=0.
5. Inject rd_data_valid while in IDLE.
   - pix_valid=0 and overrun=1, remaining 1 until rst.
6. Assert rst during burst 2.
   - Next cycle all outputs are at reset values with no frame_finish.
   - The following new_frame edge restarts from burst 0.

Source files
------------

// File: rtl/frame_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_pkg
// Description : Shared definitions for the frame-buffer handoff. Holds the
//               default burst/frame geometry, the buffer count, the read
//               controller state encoding and the buffer base-address helper.
//               The write-side controller uses the same helper, so both ends
//               agree on where each buffer lives.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buf_pkg;

    localparam int BURST_LEN    = 64;
    localparam int FRAME_BURSTS = 12288;
    localparam int FRAME_STRIDE = 786432;
    localparam int NUM_BUFFERS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_REQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } frame_state_t;

    // Word address of the first word of buffer idx. The product is formed in
    // 64 bits; the caller truncates to its own address width, which gives the
    // required modulo-2^ADDR_W wrap. The stride is a constant at every call
    // site, so synthesis reduces this to shifts and adds.
    function automatic logic [63:0] base_addr(input logic [1:0]  idx,
                                              input logic [63:0] stride);
        return {62'd0, idx} * stride;
    endfunction

endpackage : frame_buf_pkg
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_rise
// Description : Rising-edge detector. One delay flop plus an AND gate.
//               The delay flop resets to 0, so an input that is already high
//               when reset is released produces a rise on the first cycle.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               d    - level input
//               rise - high for the cycle in which d is 1 and was 0 before
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= 1'b0;
        end else begin
            r_d <= d;
        end
    end

    assign rise = d & ~r_d;

endmodule : edge_detect_rise
`default_nettype wire

// File: rtl/frame_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_read_ctrl
// Description : Consumer end of the frame-buffer handoff. On a rising edge of
//               new_frame it waits for the generator's index to settle,
//               latches read_index, reads the selected buffer as a sequence of
//               fixed-length bursts (one outstanding at a time) and forwards
//               every returned word to the pixel FIFO. frame_finish pulses
//               once the last word of the frame has been forwarded.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               new_frame           - level flag, rising edge starts a frame
//               read_index          - buffer to read, settled 2 cycles later
//               rd_req/rd_addr/rd_len/rd_ack - burst request handshake
//               rd_data_valid/rd_data        - returned read beats
//               pix_afull           - downstream FIFO almost full
//               pix_valid/pix_data  - pixel write port
//               frame_finish        - one-cycle end-of-frame pulse
//               busy                - frame in progress (ARM through DONE)
//               overrun             - sticky: a beat arrived outside DATA
// Revision    : 1.0 - initial release
// ============================================================================
module frame_read_ctrl #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = frame_buf_pkg::BURST_LEN,
    parameter int FRAME_BURSTS = frame_buf_pkg::FRAME_BURSTS,
    parameter int FRAME_STRIDE = frame_buf_pkg::FRAME_STRIDE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_frame,
    input  logic [1:0]        read_index,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              pix_afull,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_finish,
    output logic              busy,
    output logic              overrun
);

    import frame_buf_pkg::*;

    localparam int C_BEAT_W = $clog2(BURST_LEN);
    localparam int C_BC_W   = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    frame_state_t        r_state;
    logic                r_arm_cnt;
    logic [1:0]          r_idx;
    logic [C_BC_W-1:0]   r_burst_cnt;
    logic [C_BEAT_W-1:0] r_beat_cnt;
    logic                r_pending;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_pix_valid;
    logic [DATA_W-1:0]   r_pix_data;
    logic                r_overrun;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    frame_state_t        w_state_nxt;
    logic                w_arm_nxt;
    logic [1:0]          w_idx_nxt;
    logic [C_BC_W-1:0]   w_burst_nxt;
    logic [C_BEAT_W-1:0] w_beat_nxt;
    logic                w_pending_nxt;
    logic                w_rd_req_nxt;
    logic [ADDR_W-1:0]   w_rd_addr_nxt;
    logic                w_accept;
    logic                w_start;
    logic [ADDR_W-1:0]   w_burst_addr;

    edge_detect_rise u_new_frame_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (new_frame),
        .rise (w_start)
    );

    // Buffer base plus burst offset; the burst offset is a shift because
    // BURST_LEN is a power of two. Truncation to ADDR_W gives the wrap.
    assign w_burst_addr = ADDR_W'(base_addr(r_idx, 64'(FRAME_STRIDE)) +
                                  (64'(r_burst_cnt) << C_BEAT_W));

    // ------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_nxt     = r_arm_cnt;
        w_idx_nxt     = r_idx;
        w_burst_nxt   = r_burst_cnt;
        w_beat_nxt    = r_beat_cnt;
        w_pending_nxt = r_pending;
        w_rd_req_nxt  = r_rd_req;
        w_rd_addr_nxt = r_rd_addr;
        w_accept      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start || r_pending) begin
                    w_state_nxt   = ST_ARM;
                    w_pending_nxt = 1'b0;
                    w_arm_nxt     = 1'b0;
                end
            end

            // Two cycles give the generator time to update read_index
            // after raising new_frame.
            ST_ARM: begin
                if (w_start) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_arm_cnt) begin
                    w_idx_nxt   = read_index;
                    w_burst_nxt = '0;
                    w_beat_nxt  = '0;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_arm_nxt = 1'b1;
                end
            end

            // Back-pressure is honoured only before a request goes out;
            // once rd_req is up it stays up with a frozen address until ack.
            ST_REQ: begin
                if (w_start) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_rd_req) begin
                    if (rd_ack) begin
                        w_rd_req_nxt = 1'b0;
                        w_state_nxt  = ST_DATA;
                    end
                end else if (!pix_afull) begin
                    w_rd_req_nxt  = 1'b1;
                    w_rd_addr_nxt = w_burst_addr;
                end
            end

            ST_DATA: begin
                if (w_start) begin
                    w_pending_nxt = 1'b1;
                end
                if (rd_data_valid) begin
                    w_accept = 1'b1;
                    if (r_beat_cnt == C_BEAT_W'(BURST_LEN - 1)) begin
                        w_beat_nxt = '0;
                        if (r_burst_cnt == C_BC_W'(FRAME_BURSTS - 1)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_burst_nxt = r_burst_cnt + 1'b1;
                            w_state_nxt = ST_REQ;
                        end
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            // A start queued during the frame (or arriving right now) goes
            // straight to ARM so the next frame begins without an idle gap.
            ST_DONE: begin
                if (w_start || r_pending) begin
                    w_state_nxt   = ST_ARM;
                    w_pending_nxt = 1'b0;
                    w_arm_nxt     = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_arm_cnt   <= 1'b0;
            r_idx       <= 2'd0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_pending   <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_arm_cnt   <= w_arm_nxt;
            r_idx       <= w_idx_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_pending   <= w_pending_nxt;
            r_rd_req    <= w_rd_req_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_pix_valid <= w_accept;
            if (w_accept) begin
                r_pix_data <= rd_data;
            end
            // Beats outside DATA are discarded; remember that it happened.
            if (rd_data_valid && (r_state != ST_DATA)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_req       = r_rd_req;
    assign rd_addr      = r_rd_addr;
    assign rd_len       = 8'(BURST_LEN - 1);
    assign pix_valid    = r_pix_valid;
    assign pix_data     = r_pix_data;
    assign frame_finish = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign overrun      = r_overrun;

endmodule : frame_read_ctrl
`default_nettype wire

// File: tb/tb_frame_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_read_ctrl
// Description : Bench for frame_read_ctrl in a small geometry (4-word bursts,
//               3 bursts per frame, 16-word buffer stride). A memory model
//               acknowledges each request one cycle later and returns four
//               random words two cycles after the ack. Expected burst
//               addresses come from index*stride + burst*len per frame;
//               expected pixels are the words the memory model returned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_read_ctrl;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int BL     = 4;
    localparam int FB     = 3;
    localparam int FS     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              new_frame;
    logic [1:0]        read_index;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              pix_afull;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              frame_finish;
    logic              busy;
    logic              overrun;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_pix[$];
    int fin_cnt      = 0;
    int pix_in_frame = 0;
    int inj_cnt      = 0;
    int inj_done     = 0;

    always #5 clk = ~clk;

    frame_read_ctrl #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BURST_LEN    (BL),
        .FRAME_BURSTS (FB),
        .FRAME_STRIDE (FS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .new_frame     (new_frame),
        .read_index    (read_index),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .pix_afull     (pix_afull),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .frame_finish  (frame_finish),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Expected request addresses for one whole frame from buffer idx.
    task automatic push_frame(input int idx);
        for (int b = 0; b < FB; b++) begin
            q_addr.push_back(32'((idx * FS + b * BL) % (1 << ADDR_W)));
        end
    endtask

    task automatic wait_req_level(input logic lvl, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_req !== lvl && n < 200);
        check(tag, 32'(rd_req), 32'(lvl));
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_finish !== 1'b1 && n < 400);
        check(tag, 32'(frame_finish), 32'd1);
    endtask

    // Memory model and output monitor, evaluated 2 time units after each
    // rising edge so DUT outputs are settled and new inputs are set up.
    initial begin
        int          age;
        int          beat_wait;
        int          beats_left;
        logic        req_prev;
        logic [31:0] held;
        logic [31:0] e;
        logic [31:0] d;
        age = 0; beat_wait = 0; beats_left = 0;
        req_prev = 1'b0; held = 32'd0;
        rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pix_in_frame = 0;
            end else begin
                if (rd_req && !req_prev) begin
                    if (q_addr.size() == 0) begin
                        check("req_extra", 32'(rd_req), 32'd0);
                    end else begin
                        e = q_addr.pop_front();
                        held = e;
                        check("req_addr", 32'(rd_addr), e);
                    end
                end else if (rd_req) begin
                    check("addr_hold", 32'(rd_addr), held);
                end
                if (pix_valid) begin
                    pix_in_frame++;
                    if (q_pix.size() == 0) begin
                        check("pix_extra", 32'(pix_valid), 32'd0);
                    end else begin
                        e = q_pix.pop_front();
                        check("pix_data", pix_data, e);
                    end
                end
                if (frame_finish) begin
                    fin_cnt++;
                    check("pix_count", 32'(pix_in_frame), 32'(FB * BL));
                    pix_in_frame = 0;
                end
            end
            req_prev = rd_req;

            rd_ack = 1'b0;
            rd_data_valid = 1'b0;
            if (rst) begin
                age = 0; beats_left = 0; beat_wait = 0;
            end else begin
                if (beats_left > 0) begin
                    if (beat_wait > 0) begin
                        beat_wait--;
                    end else begin
                        d = $urandom;
                        rd_data = d;
                        rd_data_valid = 1'b1;
                        q_pix.push_back(d);
                        beats_left--;
                    end
                end
                if (rd_req) begin
                    if (age == 0) begin
                        age = 1;
                    end else if (age == 1) begin
                        rd_ack = 1'b1;
                        age = 2;
                        beat_wait = 1;
                        beats_left = BL;
                    end
                end else begin
                    age = 0;
                end
                if (inj_cnt != inj_done && beats_left == 0) begin
                    rd_data_valid = 1'b1;
                    rd_data = 32'hA5A5_0000 | 32'(inj_done);
                    inj_done++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int fin_before;
        rst = 1'b1; new_frame = 1'b1; read_index = 2'd2; pix_afull = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_req",  32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_pix_vld", 32'(pix_valid), 32'd0);
        check("rst_pix_dat", pix_data, 32'd0);
        check("rst_finish",  32'(frame_finish), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rd_len",      32'(rd_len), 32'(BL - 1));

        // Frame A: new_frame already high when reset is released.
        push_frame(2);
        rst = 1'b0;
        wait_finish("fin_a");
        @(negedge clk);
        check("idle_after_a", 32'(busy), 32'd0);

        // Frame B: generator drops and re-raises new_frame with index 3.
        new_frame = 1'b0;
        repeat (3) @(negedge clk);
        read_index = 2'd3;
        push_frame(3);
        new_frame = 1'b1;
        wait_req_level(1'b1, "req_b0");
        pix_afull = 1'b1;
        wait_req_level(1'b0, "ack_b0");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("afull_hold", 32'(rd_req), 32'd0);
        end
        pix_afull = 1'b0;
        wait_req_level(1'b1, "req_b1");
        wait_req_level(1'b0, "ack_b1");
        // New start while burst 1 is in flight: must be queued.
        new_frame = 1'b0;
        @(negedge clk);
        read_index = 2'd1;
        push_frame(1);
        new_frame = 1'b1;
        wait_finish("fin_b");
        @(negedge clk);
        check("pending_arm", 32'(busy), 32'd1);
        check("ovr_b", 32'(overrun), 32'd0);
        wait_finish("fin_c");
        @(negedge clk);
        check("idle_after_c", 32'(busy), 32'd0);

        // Stray data beat while idle.
        repeat (3) @(negedge clk);
        inj_cnt++;
        repeat (2) @(negedge clk);
        check("inj_pix", 32'(pix_valid), 32'd0);
        check("inj_ovr", 32'(overrun), 32'd1);
        repeat (10) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("inj_idle", 32'(busy), 32'd0);

        // Frame D: reset while the burst 2 request is pending.
        new_frame = 1'b0;
        repeat (2) @(negedge clk);
        read_index = 2'd0;
        push_frame(0);
        new_frame = 1'b1;
        wait_req_level(1'b1, "req_d0");
        wait_req_level(1'b0, "ack_d0");
        wait_req_level(1'b1, "req_d1");
        wait_req_level(1'b0, "ack_d1");
        wait_req_level(1'b1, "req_d2");
        fin_before = fin_cnt;
        rst = 1'b1;
        new_frame = 1'b0;
        @(negedge clk);
        check("mid_rd_req",  32'(rd_req), 32'd0);
        check("mid_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_pix_vld", 32'(pix_valid), 32'd0);
        check("mid_pix_dat", pix_data, 32'd0);
        check("mid_finish",  32'(frame_finish), 32'd0);
        check("mid_busy",    32'(busy), 32'd0);
        check("mid_overrun", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_restart", 32'(busy), 32'd0);
        check("no_fin_rst", 32'(fin_cnt), 32'(fin_before));
        check("addr_q_d", 32'(q_addr.size()), 32'd0);

        // Frame E: fresh edge restarts from burst 0.
        read_index = 2'd2;
        push_frame(2);
        new_frame = 1'b1;
        wait_finish("fin_e");
        @(negedge clk);
        check("idle_after_e", 32'(busy), 32'd0);
        check("frames", 32'(fin_cnt), 32'd4);
        check("addr_left", 32'(q_addr.size()), 32'd0);
        check("pix_left", 32'(q_pix.size()), 32'd0);
        check("ovr_e", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_frame_read_ctrl
`default_nettype wire
